somatorio_controle: RTL and testbench
=====================================

// Module: somatorio_controle
// PURPOSE
//  Sequencer for the 8-bit accumulator datapath (somatorio_datapath).
//  On start: clears the accumulator, accepts exactly N samples over a valid/ready
//    stream, gating each into the datapath's enable_sum.
//  Then latches the 8-bit sum and a sticky overflow flag, and pulses done.
//  Sits between the sample source and the datapath; owns dp_clr, dp_en and dp_ent.
// PARAMETERS
//  CNT_W       8   width of sample count n_amostras (max 2**CNT_W-1 samples)
//  STOP_ON_OV  0   1: stop accepting samples when overflow is first seen; 0: consume all N
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high
//  start       in   1      request new sum; sampled only in IDLE
//  n_amostras  in   CNT_W  number of samples; latched on accepted start
//  abort       in   1      cancel the operation in progress
//  in_valid    in   1      sample source has data
//  in_data     in   8      sample value
//  in_ready    out  1      controller accepts sample this cycle
//  dp_clr      out  1      to datapath reset (OR'd with system reset at top); registered
//  dp_en       out  1      to datapath enable_sum
//  dp_ent      out  8      to datapath ent
//  dp_soma     in   8      from datapath soma
//  dp_ov       in   1      from datapath ov
//  busy        out  1      high from the cycle after an accepted start until return to IDLE
//  done        out  1      one-cycle pulse; resultado/ov_flag valid in that cycle
//  resultado   out  8      latched final sum; holds until next done
//  ov_flag     out  1      latched: overflow occurred during the run
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, dp_clr, dp_en, busy, done, ov_flag=0; resultado=0;
//    internal count, latched N and ov_seen=0.
//  States: IDLE, CLEAR, ACCUM, SETTLE, DONE.
//  IDLE: start=1 -> latch N, go to CLEAR. start in any other state is ignored.
//  CLEAR (1 cycle): dp_clr=1 (flop output, glitch-free); count<=0; ov_seen<=0.
//    N==0 -> SETTLE, otherwise -> ACCUM.
//  ACCUM: in_ready=1; beat = in_valid & in_ready.
//    dp_en = beat; dp_ent = in_data (combinational pass-through).
//    On each beat count++; the beat with count==N-1 -> SETTLE.
//  Sticky overflow:
//    - ov_seen <= ov_seen | dp_ov in ACCUM and SETTLE.
//    - Datapath ov can drop after its 10-bit register wraps; the controller must not lose it.
//  STOP_ON_OV=1: when dp_ov=1 is seen in ACCUM, in_ready=0 in that same cycle;
//    go to SETTLE; remaining samples are not consumed.
//  SETTLE (1 cycle): no beat accepted; datapath holds the final value.
//    resultado <= dp_soma; ov_flag <= ov_seen|dp_ov; -> DONE.
//  DONE (1 cycle): done=1; busy=1; -> IDLE.
//    Latency: last beat edge -> done high 2 cycles later.
//  abort=1 in CLEAR/ACCUM/SETTLE:
//    - Takes priority: in_ready=0 and dp_en=0 that cycle; -> IDLE next edge.
//    - No done; resultado/ov_flag keep previous values.
//    - abort in IDLE/DONE is ignored.
//  Async reset mid-run: immediate return to reset values; the datapath is cleared by
//    the same reset.
//  in_valid while not ACCUM: in_ready=0, sample not consumed.
//    Source must hold data until ready (standard valid/ready).
//  Count arithmetic is CNT_W bits unsigned; N=2**CNT_W-1 completes without wrap.
// TESTING
//  1 N=3, samples 10,20,30 back-to-back -> one dp_clr pulse, 3 dp_en pulses,
//    done 2 cycles after last beat, resultado=60, ov_flag=0.
//  2 N=4, in_valid toggling 1,0,1,0,... samples 5 each -> only 4 beats counted;
//    resultado=20; in_ready never high outside ACCUM.
//  3 STOP_ON_OV=0, N=5, samples 100 each -> resultado=0xF4 (500 mod 256), ov_flag=1.
//    Also N=12 x 255 (sum 3060 wraps datapath ov) -> ov_flag still 1.
//  4 STOP_ON_OV=1, N=10, samples 200 each -> acceptance stops after 2 beats;
//    resultado=0x90 (400 mod 256), ov_flag=1; 8 samples left unconsumed.
//  5 N=0 -> CLEAR, SETTLE, DONE: done pulse, resultado=0, ov_flag=0, no beats.
//  6 abort in ACCUM after 2 of 5 beats -> IDLE next cycle, no done, previous resultado kept.
//    Async reset mid-ACCUM -> all outputs 0; start ignored while busy.

Source files
------------

// File: rtl/somatorio_controle.sv
// somatorio_controle
// Sequencer for the 8-bit accumulator datapath. When a start is accepted it
// clears the datapath and gates exactly N samples from a valid/ready stream
// into the datapath enable. It then latches the final sum and a sticky
// overflow flag, and pulses done for one cycle. Abort cancels a run without
// touching the previously latched result.

module somatorio_controle #(
    parameter int CNT_W      = 8,
    parameter int STOP_ON_OV = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_amostras,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             dp_clr,
    output logic             dp_en,
    output logic [7:0]       dp_ent,
    input  logic [7:0]       dp_soma,
    input  logic             dp_ov,
    output logic             busy,
    output logic             done,
    output logic [7:0]       resultado,
    output logic             ov_flag
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam bit STOP = (STOP_ON_OV != 0);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] n_lat;
    logic             ov_seen;
    logic             stop_now;
    logic             beat;
    logic             last_beat;

    // Handshake and datapath feed: a sample is taken only in ACCUM, and abort or
    // (optionally) a live overflow withdraw ready in the same cycle.
    always_comb begin
        stop_now  = STOP && dp_ov;
        in_ready  = (state == ST_ACCUM) && !abort && !stop_now;
        beat      = in_valid && in_ready;
        last_beat = beat && (count == (n_lat - CNT_W'(1)));
        dp_en     = beat;
        dp_ent    = in_data;
    end

    // Sequencer state plus its registered outputs (dp_clr, busy, done, result).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            n_lat     <= '0;
            ov_seen   <= 1'b0;
            dp_clr    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            resultado <= 8'd0;
            ov_flag   <= 1'b0;
        end else begin
            dp_clr <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_lat  <= n_amostras;
                        dp_clr <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        count   <= '0;
                        ov_seen <= 1'b0;
                        state   <= (n_lat == '0) ? ST_SETTLE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        ov_seen <= ov_seen | dp_ov;
                        if (beat) begin
                            count <= count + CNT_W'(1);
                        end
                        if (last_beat || stop_now) begin
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        ov_seen   <= ov_seen | dp_ov;
                        resultado <= dp_soma;
                        ov_flag   <= ov_seen | dp_ov;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_somatorio_controle.sv
// tb_somatorio_controle
// Two controllers (overflow-continue and overflow-stop) each drive a small
// behavioural 10-bit accumulator standing in for the datapath. Directed runs
// push their expected result into a queue; a monitor pops it on done.

module tb_somatorio_controle;

    typedef struct {
        logic [7:0] res;
        logic       ov;
        int         beats;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] n_amostras;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       selDut;

    logic       in_ready0, dp_clr0, dp_en0, busy0, done0, ov_flag0;
    logic [7:0] dp_ent0, resultado0;
    logic       in_ready1, dp_clr1, dp_en1, busy1, done1, ov_flag1;
    logic [7:0] dp_ent1, resultado1;

    logic [9:0] acc0, acc1;
    logic       dpRst0, dpRst1;

    logic       in_ready_m, dp_clr_m, dp_en_m, busy_m, done_m, ov_flag_m;
    logic [7:0] dp_ent_m, resultado_m;

    int   errors = 0;
    int   checks = 0;
    int   cycCnt = 0;
    int   beats = 0;
    int   lastBeat = 0;
    int   clrW = 0;
    int   rdyViol = 0;
    int   doneCount = 0;
    exp_t expQ[$];

    // Clock generation
    always #5 clk = ~clk;

    somatorio_controle #(.CNT_W(8), .STOP_ON_OV(0)) dut0 (
        .clk(clk), .reset(reset), .start(start & ~selDut), .n_amostras(n_amostras),
        .abort(abort & ~selDut), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .dp_clr(dp_clr0), .dp_en(dp_en0), .dp_ent(dp_ent0),
        .dp_soma(acc0[7:0]), .dp_ov(|acc0[9:8]), .busy(busy0), .done(done0),
        .resultado(resultado0), .ov_flag(ov_flag0)
    );

    somatorio_controle #(.CNT_W(8), .STOP_ON_OV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start & selDut), .n_amostras(n_amostras),
        .abort(abort & selDut), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .dp_clr(dp_clr1), .dp_en(dp_en1), .dp_ent(dp_ent1),
        .dp_soma(acc1[7:0]), .dp_ov(|acc1[9:8]), .busy(busy1), .done(done1),
        .resultado(resultado1), .ov_flag(ov_flag1)
    );

    assign dpRst0 = reset | dp_clr0;
    assign dpRst1 = reset | dp_clr1;

    // Datapath stand-in for the continue-on-overflow controller
    always @(posedge clk or posedge dpRst0) begin
        if (dpRst0) acc0 <= 10'd0;
        else if (dp_en0) acc0 <= acc0 + {2'b00, dp_ent0};
    end

    // Datapath stand-in for the stop-on-overflow controller
    always @(posedge clk or posedge dpRst1) begin
        if (dpRst1) acc1 <= 10'd0;
        else if (dp_en1) acc1 <= acc1 + {2'b00, dp_ent1};
    end

    assign in_ready_m  = selDut ? in_ready1  : in_ready0;
    assign dp_clr_m    = selDut ? dp_clr1    : dp_clr0;
    assign dp_en_m     = selDut ? dp_en1     : dp_en0;
    assign dp_ent_m    = selDut ? dp_ent1    : dp_ent0;
    assign busy_m      = selDut ? busy1      : busy0;
    assign done_m      = selDut ? done1      : done0;
    assign resultado_m = selDut ? resultado1 : resultado0;
    assign ov_flag_m   = selDut ? ov_flag1   : ov_flag0;

    // Cycle counter used for latency measurement
    always @(posedge clk) cycCnt <= cycCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: handshake consistency, dp_clr width, and scoreboard pop on done
    always @(negedge clk) begin
        if (reset) begin
            clrW  = 0;
            beats = 0;
        end else begin
            if (in_valid) checkOutput("dp_en_handshake", 32'(dp_en_m), 32'(in_valid & in_ready_m));
            if (dp_en_m) begin
                beats++;
                lastBeat = cycCnt;
                checkOutput("dp_ent_pass", 32'(dp_ent_m), 32'(in_data));
            end
            if (in_ready_m && (!busy_m || dp_clr_m || done_m)) rdyViol++;
            if (dp_clr_m) begin
                clrW++;
                beats = 0;
            end else if (clrW != 0) begin
                checkOutput("dp_clr_width", clrW, 1);
                clrW = 0;
            end
            if (done_m) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("resultado", 32'(resultado_m), 32'(e.res));
                    checkOutput("ov_flag", 32'(ov_flag_m), 32'(e.ov));
                    checkOutput("beat_count", beats, e.beats);
                    if (e.lat >= 0) checkOutput("done_latency", cycCnt - lastBeat, e.lat);
                    checkOutput("ready_outside_accum", rdyViol, 0);
                    checkOutput("busy_in_done", 32'(busy_m), 1);
                end
                rdyViol = 0;
            end
        end
    end

    task automatic applyStimulus(input int n, input logic [7:0] val, input logic [7:0] step,
                                 input bit toggle, input logic sel, input bit pokeStart,
                                 input logic [7:0] expRes, input logic expOv,
                                 input int expBeats, input int expLat);
        exp_t e;
        int   idx = 0;
        int   dc0;
        bit   finished = 0;
        bit   poked = 0;
        e.res = expRes; e.ov = expOv; e.beats = expBeats; e.lat = expLat;
        @(posedge clk); #1;
        selDut = sel;
        n_amostras = n[7:0];
        start = 1'b1;
        expQ.push_back(e);
        dc0 = doneCount;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 300 && !finished; c++) begin
            in_valid = (toggle ? (c % 2 == 0) : 1'b1) && (idx < n);
            in_data  = val + 8'(idx) * step;
            if (pokeStart && idx == 1 && !poked) begin
                start = 1'b1;
                n_amostras = 8'd1;
                poked = 1;
            end
            @(negedge clk);
            if (in_valid && in_ready_m) idx++;
            @(posedge clk); #1;
            start = 1'b0;
            finished = (doneCount != dc0);
        end
        in_valid = 1'b0;
        if (!finished) begin
            checkOutput("run_timeout", 0, 1);
            expQ.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_after_run", 32'(busy_m), 0);
    endtask

    task automatic startRun(input int n, input logic sel);
        @(posedge clk); #1;
        selDut = sel;
        n_amostras = n[7:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feedBeats(input int k, input logic [7:0] v);
        int got = 0;
        for (int c = 0; c < 50 && got < k; c++) begin
            in_valid = 1'b1;
            in_data  = v;
            @(negedge clk);
            if (in_ready_m) got++;
            @(posedge clk); #1;
        end
        if (got < k) checkOutput("feed_timeout", got, k);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; n_amostras = 8'd0; abort = 1'b0;
        in_valid = 1'b0; in_data = 8'd0; selDut = 1'b0;
        #12;
        checkOutput("rst_in_ready", 32'(in_ready_m), 0);
        checkOutput("rst_dp_clr", 32'(dp_clr_m), 0);
        checkOutput("rst_dp_en", 32'(dp_en_m), 0);
        checkOutput("rst_busy", 32'(busy_m), 0);
        checkOutput("rst_done", 32'(done_m), 0);
        checkOutput("rst_ov_flag", 32'(ov_flag_m), 0);
        checkOutput("rst_resultado", 32'(resultado_m), 0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(3, 8'd10, 8'd10, 0, 1'b0, 0, 8'd60, 1'b0, 3, 2);
        applyStimulus(4, 8'd5, 8'd0, 1, 1'b0, 0, 8'd20, 1'b0, 4, 2);
        applyStimulus(5, 8'd100, 8'd0, 0, 1'b0, 1, 8'hF4, 1'b1, 5, 2);
        applyStimulus(12, 8'd255, 8'd0, 0, 1'b0, 0, 8'hF4, 1'b1, 12, 2);
        applyStimulus(5, 8'd255, 8'd0, 0, 1'b0, 0, 8'hFB, 1'b1, 5, 2);

        // abort after 2 of 5 beats: no done, previous result retained
        startRun(5, 1'b0);
        feedBeats(2, 8'd7);
        abort = 1'b1;
        #1;
        checkOutput("abort_in_ready", 32'(in_ready_m), 0);
        checkOutput("abort_dp_en", 32'(dp_en_m), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort_busy", 32'(busy_m), 0);
        checkOutput("abort_resultado", 32'(resultado_m), 32'hFB);
        checkOutput("abort_ov_flag", 32'(ov_flag_m), 1);
        repeat (4) @(posedge clk);

        applyStimulus(10, 8'd200, 8'd0, 0, 1'b1, 0, 8'h90, 1'b1, 2, 3);
        applyStimulus(0, 8'd1, 8'd0, 0, 1'b0, 0, 8'd0, 1'b0, 0, -1);
        applyStimulus(2, 8'd150, 8'd0, 0, 1'b0, 0, 8'h2C, 1'b1, 2, 2);

        // asynchronous reset in the middle of ACCUM
        startRun(5, 1'b0);
        feedBeats(2, 8'd9);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy_m), 0);
        checkOutput("midrst_in_ready", 32'(in_ready_m), 0);
        checkOutput("midrst_dp_en", 32'(dp_en_m), 0);
        checkOutput("midrst_resultado", 32'(resultado_m), 0);
        checkOutput("midrst_ov_flag", 32'(ov_flag_m), 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(3, 8'd1, 8'd1, 0, 1'b0, 0, 8'd6, 1'b0, 3, 2);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
